// File: rtl/fetch_buffer.sv
// Instruction fetch buffer between fetch and decode: a small circular queue of
// {pc, instr} pairs with valid/ready on both sides, flushed on redirect.
module fetch_buffer #(
    parameter int          DEPTH = 2,
    parameter logic [31:0] NOP   = 32'h00000013
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [31:0]              in_pc,
    input  logic [31:0]              in_instr,
    input  logic                     flush,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [31:0]              out_pc,
    output logic [31:0]              out_pc4,
    output logic [31:0]              out_instr,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [31:0]   mem_pc    [DEPTH];
    logic [31:0]   mem_instr [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic          push;
    logic          pop;

    // in_ready comes only from the registered count, so a pop never frees a slot
    // for a push in the same cycle.
    assign in_ready  = (count != CW'(DEPTH));
    assign out_valid = (count != '0);
    assign push      = in_valid & in_ready & ~flush;
    assign pop       = out_valid & out_ready & ~flush;

    always_ff @(posedge clk) begin
        if (!rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push)
                wr_ptr <= wr_ptr + AW'(1);
            if (pop)
                rd_ptr <= rd_ptr + AW'(1);
            if (push && !pop)
                count <= count + CW'(1);
            else if (pop && !push)
                count <= count - CW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem_pc[wr_ptr]    <= in_pc;
            mem_instr[wr_ptr] <= in_instr;
        end
    end

    // Bubble values are muxed in whenever empty so stale or X payload never leaks out.
    assign out_pc    = out_valid ? mem_pc[rd_ptr]            : 32'd0;
    assign out_pc4   = out_valid ? mem_pc[rd_ptr] + 32'd4    : 32'd4;
    assign out_instr = out_valid ? mem_instr[rd_ptr]         : NOP;

endmodule

// File: doc/fetch_buffer.md
# fetch_buffer

Instruction fetch buffer between the fetch stage (program counter plus instruction memory) and the decode stage of the 5-stage pipeline. It holds up to DEPTH fetched {PC, instruction} pairs with a valid/ready handshake on both sides, so decode stalls do not block the fetch side immediately. It discards all buffered instructions on a control-flow redirect: the taken-branch/jump flush pulse produced by the PC logic. When empty it presents a NOP bubble to decode.

## Interface
- DEPTH, 2, number of entries; power of two, minimum 2.
- NOP, 32'h00000013, instruction word presented when no entry is valid.

- clk  input  1  single clock; all state updates on the rising edge.
- rst  input  1  reset, synchronous, active-low: state clears on a clk edge where rst=0.
- in_valid  input  1  fetch offers in_pc/in_instr this cycle.
- in_ready  output  1  buffer can accept; equals (count != DEPTH).
- in_pc  input  32  PC of the offered instruction.
- in_instr  input  32  offered instruction word.
- flush  input  1  redirect pulse; discards all entries and any push in the same cycle.
- out_valid  output  1  head entry is valid; equals (count != 0).
- out_ready  input  1  decode consumes the head this cycle.
- out_pc  output  32  head PC; 32'd0 when out_valid=0.
- out_pc4  output  32  out_pc + 4, modulo 2^32; 32'd4 when out_valid=0.
- out_instr  output  32  head instruction; NOP when out_valid=0.
- count  output  $clog2(DEPTH)+1  number of valid entries.

## Operation
- Storage: circular array of DEPTH entries {pc, instr}. Write pointer wr_ptr and read pointer rd_ptr, each $clog2(DEPTH) bits, wrap modulo DEPTH. A separate count register distinguishes full from empty.
- push = in_valid & in_ready & ~flush. The entry is written at wr_ptr, and wr_ptr advances by 1.
- pop = out_valid & out_ready & ~flush. rd_ptr advances by 1.
- Count update:
  - push only: +1.
  - pop only: -1.
  - both: unchanged.
  - neither: unchanged.
- in_ready depends only on registered count. There is no combinational path from out_ready to in_ready: when full, no push occurs even if a pop occurs in the same cycle.
- flush (when rst=1):
  - wr_ptr, rd_ptr and count return to 0 at the next edge.
  - Entry contents are don't-care.
  - flush has priority over push and pop.
- Priority order: reset, then flush, then push/pop.
- Output muxing is combinational from registered state. The PC-zero, NOP and 4 values apply whenever count=0.
- Payload values are ignored when in_valid=0. X on in_pc/in_instr must not propagate to the outputs while count=0.

## Timing
- Reset: an edge with rst=0 sets count=0, wr_ptr=0 and rd_ptr=0. Consequently out_valid=0, out_pc=0, out_pc4=4, out_instr=NOP and in_ready=1.
- Reset mid-operation: all entries are lost at that edge, exactly like flush. in_ready is computed from count, so it may be 0 during the reset cycle if the buffer was full before that edge.
- Latency: an entry pushed at edge N is visible on out_* in the cycle after edge N. There is no same-cycle bypass from input to output.
- Throughput: one push and one pop per cycle in steady state whenever 0 < count < DEPTH.
- Full, with out_ready=1 and in_valid=1: the pop happens, no push occurs, and count becomes DEPTH-1. in_ready rises the next cycle.
- Empty, with out_ready=1: no pop occurs and the state is unchanged.
- Flush, with in_valid=1 and out_ready=1 in the same cycle: nothing is pushed and nothing is counted as consumed. The next cycle shows count=0 and the bubble outputs.
- Flush for several consecutive cycles: the buffer stays empty and in_ready=1 throughout.

## Test plan
- Reset: hold rst=0 for 2 edges with in_valid=1 -> count=0, out_valid=0, out_instr=32'h00000013, out_pc=0, out_pc4=4, in_ready=1.
- Fill and drain: push (0x100, 0xAAAA0001) then (0x104, 0xAAAA0002) with out_ready=0 -> count=2 and in_ready=0. Then set out_ready=1 -> out_pc is 0x100 then 0x104 on consecutive cycles, out_pc4 is 0x104 then 0x108, and count goes 1 then 0.
- Full with simultaneous pop and offer: buffer holding 2 entries, in_valid=1 with pc 0x108, out_ready=1 -> the 0x100 entry pops, 0x108 is not accepted, count=1. The next cycle accepts 0x108.
- Streaming: in_valid=1 and out_ready=1 for 10 cycles with pc 0x200 + 4k -> count stays at 1 after the first cycle. Outputs appear in order with 1-cycle latency, and the pointers wrap without loss.
- Flush: 2 entries buffered, assert flush with in_valid=1 (pc 0x300) and out_ready=1 -> the next cycle has count=0, out_valid=0 and out_instr=NOP. 0x300 is never output, and a push of 0x400 the following cycle appears alone at the head.
- Wrap arithmetic: push pc 32'hFFFFFFFC -> out_pc4=32'h00000000.
